// File: rtl/ireg_queue.sv
// rtl/ireg_queue.sv - fetch-to-decode instruction queue with head-entry MIPS field decode
module ireg_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ins,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      im1,
    output logic [25:0]      im2,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [31:0]      head_ins;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= in_ins;
            pc_mem[wr_ptr]  <= in_pc;
        end
    end

    assign head_ins = out_valid ? ins_mem[rd_ptr] : 32'd0;
    assign out_ins  = head_ins;
    assign out_pc   = out_valid ? pc_mem[rd_ptr] : '0;
    assign opcode   = head_ins[31:26];
    assign rs       = head_ins[25:21];
    assign rt       = head_ins[20:16];
    assign rd       = head_ins[15:11];
    assign shamt    = head_ins[10:6];
    assign funct    = head_ins[5:0];
    assign im1      = head_ins[15:0];
    assign im2      = head_ins[25:0];
endmodule

// File: tb/tb_ireg_queue.sv
// tb/tb_ireg_queue.sv - scoreboard bench for ireg_queue with a queue-based reference model
module tb_ireg_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_ins = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_ins;
    logic [PC_W-1:0]  out_pc;
    logic [5:0]       opcode;
    logic [4:0]       rs, rt, rd, shamt;
    logic [5:0]       funct;
    logic [15:0]      im1;
    logic [25:0]      im2;
    logic [CNT_W-1:0] count;

    typedef struct packed {
        logic [31:0]     ins;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t exp_q[$];
    ent_t head;
    int   checks = 0;
    int   errors = 0;

    ireg_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .im1(im1), .im2(im2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT state against the model away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                chk("out_ins", 64'(out_ins), 64'(head.ins));
                chk("out_pc", 64'(out_pc), 64'(head.pc));
                chk("opcode", 64'(opcode), 64'(head.ins[31:26]));
                chk("rs", 64'(rs), 64'(head.ins[25:21]));
                chk("rt", 64'(rt), 64'(head.ins[20:16]));
                chk("rd", 64'(rd), 64'(head.ins[15:11]));
                chk("shamt", 64'(shamt), 64'(head.ins[10:6]));
                chk("funct", 64'(funct), 64'(head.ins[5:0]));
                chk("im1", 64'(im1), 64'(head.ins[15:0]));
                chk("im2", 64'(im2), 64'(head.ins[25:0]));
                if (out_ready && !flush) void'(exp_q.pop_front());
            end else begin
                chk("empty_ins_pc", {out_ins, out_pc}, 64'd0);
                chk("empty_fields", {opcode, rs, rt, rd, shamt, funct}, 64'd0);
                chk("empty_imm", {im1, im2}, 64'd0);
            end
        end
    end

    // Drives one cycle of stimulus and records accepted words in the model.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic ordy, input logic fl);
        ent_t e;
        bit   acc;
        in_valid  = iv;
        in_ins    = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = iv && !fl && (exp_q.size() < DEPTH);
        e.ins = ins;
        e.pc  = pc;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(e);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_ins", 64'(out_ins), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known decode vector
        cycle(1'b1, 32'h6DD36A6B, 32'h400, 1'b0, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_fields", {opcode, rs, rt, rd, shamt, funct},
            {6'h1B, 5'd14, 5'd19, 5'd13, 5'd9, 6'h2B});
        chk("t1_imm", {im1, im2}, {16'h6A6B, 26'h1D36A6B});
        chk("t1_pc", 64'(out_pc), 64'h400);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Fill to full with decode stalled; fifth word must be refused
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Steady push+pop at count=2 wraps pointers
        cycle(1'b1, $urandom, 32'h100, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 32'h104, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 32'(32'h108 + i * 4), 1'b1, 1'b0);
        chk("t3_count", 64'(count), 64'd2);

        // Stall holds head stable
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Flush at count=3 with push and pop presented
        cycle(1'b1, $urandom, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 32'h204, 1'b1, 1'b1);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_out_ins", 64'(out_ins), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 32'(32'h300 + i * 4), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b1, 32'h12345678, 32'h500, 1'b0, 1'b0);
        chk("t6_head", {out_ins, out_pc}, {32'h12345678, 32'h500});

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
